// File: rtl/pll_range_pkg.sv
// Shared types and timing defaults for the push-button range stepper.
// Build with PB_RANGE_WRAP_EN defined to wrap at the range limits.
package pll_range_pkg;

  localparam int unsigned CNT_W_DEF         = 24;
  localparam int unsigned HOLD_CYCLES_DEF   = 5_000_000;
  localparam int unsigned REPEAT_CYCLES_DEF = 1_000_000;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_HOLD,
    RPT_REPEAT
  } rpt_state_e;

endpackage

// File: rtl/pb_autorepeat.sv
// One button channel: first step on press, then hold delay and auto-repeat.
// Release wins over a terminal count; force_idle parks the channel.
module pb_autorepeat
  import pll_range_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic state,
  input  logic down,
  input  logic force_idle,
  output logic step
);

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LAST =
    CNT_W'(REPEAT_CYCLES - 1);

  rpt_state_e       st_q;
  logic [CNT_W-1:0] cnt_q;
  logic             step_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= RPT_IDLE;
      cnt_q  <= '0;
      step_q <= 1'b0;
    end else begin
      step_q <= 1'b0;
      if (force_idle) begin
        st_q  <= RPT_IDLE;
        cnt_q <= '0;
      end else begin
        unique case (st_q)
          RPT_IDLE: begin
            if (down) begin
              step_q <= 1'b1;
              cnt_q  <= '0;
              st_q   <= RPT_HOLD;
            end
          end
          RPT_HOLD: begin
            if (!state) begin
              st_q  <= RPT_IDLE;
              cnt_q <= '0;
            end else if (cnt_q == HOLD_LAST) begin
              step_q <= 1'b1;
              cnt_q  <= '0;
              st_q   <= RPT_REPEAT;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          RPT_REPEAT: begin
            if (!state) begin
              st_q  <= RPT_IDLE;
              cnt_q <= '0;
            end else if (cnt_q == RPT_LAST) begin
              step_q <= 1'b1;
              cnt_q  <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            st_q  <= RPT_IDLE;
            cnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign step = step_q;

endmodule

// File: rtl/pb_range_stepper.sv
// UP/DOWN buttons to registered PLL range index with repeat and combo reset.
// PB_RANGE_WRAP_EN: wrap at the limits instead of saturating.
module pb_range_stepper
  import pll_range_pkg::*;
#(
  parameter int unsigned NUM_RANGES    = 8,
  parameter int unsigned DEFAULT_RANGE = 3,
  parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          up_state,
  input  logic                          up_down,
  input  logic                          dn_state,
  input  logic                          dn_down,
  output logic [$clog2(NUM_RANGES)-1:0] range_idx,
  output logic                          range_changed,
  output logic                          combo_evt
);

  localparam int unsigned IDX_W = $clog2(NUM_RANGES);
  localparam logic [IDX_W-1:0] MAX_IDX =
    IDX_W'(NUM_RANGES - 1);
  localparam logic [IDX_W-1:0] DEF_IDX =
    IDX_W'(DEFAULT_RANGE);

  logic             up_step;
  logic             dn_step;
  logic             combo;
  logic             both_held;
  logic             force_idle;
  logic [IDX_W-1:0] range_q;
  logic [IDX_W-1:0] range_d;
  logic             changed_q;
  logic             combo_q;

  // Simultaneous presses are not a combo: both steps fire and cancel.
  assign combo = (up_down & dn_state & ~dn_down)
               | (dn_down & up_state & ~up_down);
  assign both_held  = up_state & dn_state & ~(up_down & dn_down);
  assign force_idle = combo | both_held;

  pb_autorepeat #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES),
    .CNT_W        (CNT_W)
  ) u_up (
    .clk       (clk),
    .rst_n     (rst_n),
    .state     (up_state),
    .down      (up_down),
    .force_idle(force_idle),
    .step      (up_step)
  );

  pb_autorepeat #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES),
    .CNT_W        (CNT_W)
  ) u_dn (
    .clk       (clk),
    .rst_n     (rst_n),
    .state     (dn_state),
    .down      (dn_down),
    .force_idle(force_idle),
    .step      (dn_step)
  );

  always_comb begin
    range_d = range_q;
    unique case (1'b1)
      combo: range_d = DEF_IDX;
      (~combo & up_step & ~dn_step): begin
`ifdef PB_RANGE_WRAP_EN
        range_d = (range_q == MAX_IDX) ? '0
                                       : range_q + 1'b1;
`else
        range_d = (range_q == MAX_IDX) ? range_q
                                       : range_q + 1'b1;
`endif
      end
      (~combo & dn_step & ~up_step): begin
`ifdef PB_RANGE_WRAP_EN
        range_d = (range_q == '0) ? MAX_IDX
                                  : range_q - 1'b1;
`else
        range_d = (range_q == '0) ? range_q
                                  : range_q - 1'b1;
`endif
      end
      default: range_d = range_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      range_q   <= DEF_IDX;
      changed_q <= 1'b0;
      combo_q   <= 1'b0;
    end else begin
      range_q   <= range_d;
      changed_q <= (range_d != range_q);
      combo_q   <= combo;
    end
  end

  assign range_idx     = range_q;
  assign range_changed = changed_q;
  assign combo_evt     = combo_q;

endmodule
